// File: rtl/ran_health_packer.sv
// Online RCT/APT health monitor and MSB-first byte packer for the post-processed
// random bit stream, feeding a small first-word-fall-through byte FIFO.
module ran_health_packer #(
  parameter int WARMUP_BITS = 64,
  parameter int RCT_CUTOFF  = 32,
  parameter int APT_WINDOW  = 512,
  parameter int APT_CUTOFF  = 410,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            bit_in,
  input  logic                            bit_valid,
  input  logic                            clear_fail,
  output logic [7:0]                      byte_out,
  output logic                            byte_valid,
  input  logic                            byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow,
  output logic                            health_fail,
  output logic [1:0]                      fail_code
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int AW = $clog2(APT_WINDOW);
  localparam int CW = $clog2(APT_CUTOFF + 1);
  localparam int WW = $clog2(WARMUP_BITS);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_FAIL} state_t;

  state_t        state_reg, state_next;
  logic [RW-1:0] rct_cnt_reg, rct_cnt_inc;
  logic          rct_last_reg;
  logic [AW-1:0] apt_pos_reg, apt_pos_inc;
  logic [CW-1:0] apt_cnt_reg, apt_cnt_inc;
  logic          apt_ref_reg;
  logic [WW-1:0] warm_cnt_reg;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt_reg;
  logic [1:0]    fail_code_reg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg, rd_ptr_next, wr_ptr_next;
  logic [LW-1:0] level_reg, level_next;
  logic [7:0]    head_reg, head_next;
  logic          overflow_reg;

  logic active, take, rct_trip, apt_trip, trip, warm_done;
  logic push_req, push_ok, pop, full, drop;
  logic [7:0] push_byte;

  assign active    = enable && (state_reg == S_WARMUP || state_reg == S_RUN);
  assign take      = active && bit_valid;

  // A zero run counter means no previous bit has been seen since the last clear.
  always_comb begin
    rct_cnt_inc = RW'(1);
    if (rct_cnt_reg != '0 && bit_in == rct_last_reg)
      rct_cnt_inc = rct_cnt_reg + RW'(1);
  end

  always_comb begin
    apt_cnt_inc = CW'(1);
    if (apt_pos_reg != '0)
      apt_cnt_inc = apt_cnt_reg + CW'(bit_in == apt_ref_reg);
    apt_pos_inc = (apt_pos_reg == AW'(APT_WINDOW - 1)) ? '0 : apt_pos_reg + AW'(1);
  end

  assign rct_trip  = take && (rct_cnt_inc == RW'(RCT_CUTOFF));
  assign apt_trip  = take && (apt_cnt_inc == CW'(APT_CUTOFF));
  assign trip      = rct_trip || apt_trip;
  assign warm_done = take && !trip && state_reg == S_WARMUP
                     && warm_cnt_reg == WW'(WARMUP_BITS - 1);
  assign push_byte = {shift_reg[6:0], bit_in};
  assign push_req  = take && !trip && state_reg == S_RUN && bit_cnt_reg == 3'd7;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:   state_next = S_WARMUP;
        S_WARMUP: if (trip) state_next = S_FAIL;
                  else if (warm_done) state_next = S_RUN;
        S_RUN:    if (trip) state_next = S_FAIL;
        S_FAIL:   if (clear_fail) state_next = S_WARMUP;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    health_fail = (state_reg == S_FAIL);
    fail_code   = fail_code_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rct_cnt_reg   <= '0;
      rct_last_reg  <= 1'b0;
      apt_pos_reg   <= '0;
      apt_cnt_reg   <= '0;
      apt_ref_reg   <= 1'b0;
      warm_cnt_reg  <= '0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      fail_code_reg <= '0;
    end else if (!enable || (state_reg == S_FAIL && clear_fail)) begin
      rct_cnt_reg   <= '0;
      rct_last_reg  <= 1'b0;
      apt_pos_reg   <= '0;
      apt_cnt_reg   <= '0;
      apt_ref_reg   <= 1'b0;
      warm_cnt_reg  <= '0;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      fail_code_reg <= '0;
    end else if (take) begin
      rct_cnt_reg  <= rct_cnt_inc;
      rct_last_reg <= bit_in;
      apt_pos_reg  <= apt_pos_inc;
      apt_cnt_reg  <= apt_cnt_inc;
      if (apt_pos_reg == '0)
        apt_ref_reg <= bit_in;
      if (trip) begin
        fail_code_reg <= {apt_trip, rct_trip};
        shift_reg     <= '0;
        bit_cnt_reg   <= '0;
      end else if (state_reg == S_WARMUP) begin
        warm_cnt_reg <= warm_cnt_reg + WW'(1);
      end else begin
        shift_reg   <= push_byte;
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
      end
    end
  end

  assign byte_valid = (level_reg != '0);
  assign pop        = byte_valid && byte_ready;
  assign full       = (level_reg == LW'(FIFO_DEPTH));
  assign push_ok    = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;

  // A health trip flushes the FIFO so untested data is never delivered.
  always_comb begin
    rd_ptr_next = rd_ptr_reg + PW'(pop);
    wr_ptr_next = wr_ptr_reg + PW'(push_ok);
    level_next  = level_reg + LW'(push_ok) - LW'(pop);
    if (trip) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      level_next  = '0;
    end
    head_next = mem[rd_ptr_next];
    if (push_ok && wr_ptr_reg == rd_ptr_next)
      head_next = push_byte;
    if (level_next == '0)
      head_next = 8'h00;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      level_reg    <= '0;
      head_reg     <= 8'h00;
      overflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      level_reg  <= level_next;
      head_reg   <= head_next;
      if (!enable)   overflow_reg <= 1'b0;
      else if (drop) overflow_reg <= 1'b1;
    end
  end

  assign byte_out   = head_reg;
  assign fifo_level = level_reg;
  assign overflow   = overflow_reg;

endmodule

// File: tb/tb_ran_health_packer.sv
// Scoreboard bench for ran_health_packer: a behavioural model predicts FIFO
// contents and status; a negedge monitor compares the DUT against it.
module tb_ran_health_packer;

  localparam int WARMUP = 64;
  localparam int RCT_C  = 32;
  localparam int APT_W  = 512;
  localparam int APT_C  = 410;
  localparam int DEPTH  = 4;
  localparam int M_IDLE = 0, M_WARM = 1, M_RUN = 2, M_FAIL = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       clear_fail = 1'b0;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready = 1'b0;
  logic [2:0] fifo_level;
  logic       overflow;
  logic       health_fail;
  logic [1:0] fail_code;

  int n_vec = 0;
  int n_err = 0;

  ran_health_packer #(
    .WARMUP_BITS(WARMUP), .RCT_CUTOFF(RCT_C), .APT_WINDOW(APT_W),
    .APT_CUTOFF(APT_C), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bit_in(bit_in),
    .bit_valid(bit_valid), .clear_fail(clear_fail), .byte_out(byte_out),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .fifo_level(fifo_level),
    .overflow(overflow), .health_fail(health_fail), .fail_code(fail_code)
  );

  always #5 clk = ~clk;

  // Behavioural model
  int         m_state, m_run, m_wpos, m_cnt, m_warm;
  logic       m_last, m_ref, m_ovf;
  logic [1:0] m_fc;
  logic       m_bits[$];
  logic [7:0] mq[$];
  logic [7:0] seen_q[$];

  task automatic m_clear();
    m_run = 0; m_wpos = 0; m_cnt = 0; m_warm = 0; m_last = 0; m_ref = 0;
    m_bits.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    bit pop_m, push_m, rct, apt;
    logic [7:0] val;
    if (!rst_n) begin
      m_state = M_IDLE; m_fc = 0; m_ovf = 0; m_clear(); mq.delete();
    end else begin
      pop_m = byte_ready && mq.size() > 0;
      push_m = 0; val = 0; rct = 0; apt = 0;
      if (!enable) begin
        m_state = M_IDLE; m_clear(); m_fc = 0; m_ovf = 0;
      end else begin
        case (m_state)
          M_IDLE: m_state = M_WARM;
          M_WARM, M_RUN: if (bit_valid) begin
            if (m_run == 0 || bit_in != m_last) m_run = 1; else m_run++;
            m_last = bit_in;
            if (m_wpos == 0) begin m_ref = bit_in; m_cnt = 1; end
            else if (bit_in == m_ref) m_cnt++;
            m_wpos = (m_wpos + 1) % APT_W;
            rct = (m_run == RCT_C);
            apt = (m_cnt == APT_C);
            if (rct || apt) begin
              m_fc = {apt, rct}; m_state = M_FAIL; m_bits.delete();
            end else if (m_state == M_WARM) begin
              m_warm++;
              if (m_warm == WARMUP) m_state = M_RUN;
            end else begin
              m_bits.push_back(bit_in);
              if (m_bits.size() == 8) begin
                foreach (m_bits[i]) val = val * 2 + 8'(m_bits[i]);
                push_m = 1; m_bits.delete();
              end
            end
          end
          M_FAIL: if (clear_fail) begin
            m_state = M_WARM; m_clear(); m_fc = 0;
          end
          default: m_state = M_IDLE;
        endcase
      end
      if (rct || apt) mq.delete();
      else begin
        if (pop_m) void'(mq.pop_front());
        if (push_m) begin
          if (mq.size() < DEPTH) mq.push_back(val);
          else m_ovf = 1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      check("byte_valid", int'(byte_valid), int'(mq.size() != 0));
      check("fifo_level", int'(fifo_level), mq.size());
      check("overflow", int'(overflow), int'(m_ovf));
      check("health_fail", int'(health_fail), int'(m_state == M_FAIL));
      check("fail_code", int'(fail_code), int'(m_fc));
      if (byte_valid && mq.size() > 0) begin
        check("byte_out", int'(byte_out), int'(mq[0]));
        if (byte_ready) begin
          seen_q.push_back(byte_out);
          $display("pop byte_out=%02h level=%0d", byte_out, fifo_level);
        end
      end
    end
  end

  task automatic feed(input logic b);
    bit_in = b; bit_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic feed_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) feed(v[i]);
  endtask

  task automatic restart();
    enable = 1'b0; idle(1);
    enable = 1'b1; idle(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_out"}, int'(byte_out), 0);
    check({tag, "_byte_valid"}, int'(byte_valid), 0);
    check({tag, "_level"}, int'(fifo_level), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_health_fail"}, int'(health_fail), 0);
    check({tag, "_fail_code"}, int'(fail_code), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bias;
    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    enable = 1'b1; byte_ready = 1'b1;
    idle(1);

    // Warm-up then 8'hAA
    seen_q.delete();
    for (int i = 0; i < WARMUP; i++) feed(logic'($urandom_range(0, 1)));
    check("warmup_no_byte", int'(byte_valid), 0);
    for (int i = 0; i < 8; i++) feed(logic'(i % 2 == 0));
    bit_valid = 1'b0;
    check("first_byte_valid", int'(byte_valid), 1);
    check("first_byte_value", int'(byte_out), 8'hAA);
    idle(1);
    check("first_level_after_pop", int'(fifo_level), 0);

    // RCT trip on 32 ones
    for (int i = 0; i < 32; i++) feed(1'b1);
    bit_valid = 1'b0;
    check("rct_health_fail", int'(health_fail), 1);
    check("rct_fail_code", int'(fail_code), 2'b01);
    check("rct_level", int'(fifo_level), 0);
    for (int i = 0; i < 16; i++) feed(logic'($urandom_range(0, 1)));
    idle(1);
    check("fail_no_bytes", int'(byte_valid), 0);

    // clear_fail, warm-up again, two 8'hAA bytes
    seen_q.delete();
    clear_fail = 1'b1; idle(1); clear_fail = 1'b0;
    check("clear_fail_code", int'(fail_code), 0);
    check("clear_health", int'(health_fail), 0);
    for (int i = 0; i < WARMUP + 16; i++) feed(logic'(i % 2 == 0));
    idle(3);
    check("clear_bytes_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      check("clear_byte0", int'(seen_q[0]), 8'hAA);
      check("clear_byte1", int'(seen_q[1]), 8'hAA);
    end

    // APT trip at bit 423 of a window of 31 ones + 1 zero
    restart();
    for (int i = 0; i < 422; i++) feed(logic'(i % 32 != 31));
    bit_valid = 1'b0;
    check("apt_before_trip", int'(health_fail), 0);
    feed(1'b1);
    bit_valid = 1'b0;
    check("apt_health_fail", int'(health_fail), 1);
    check("apt_fail_code", int'(fail_code), 2'b10);
    idle(2);

    // Overflow: 5 bytes with no reader
    restart();
    byte_ready = 1'b0;
    for (int i = 0; i < WARMUP; i++) feed(logic'($urandom_range(0, 1)));
    for (int v = 1; v <= 5; v++) feed_byte(8'(v));
    bit_valid = 1'b0;
    check("ovf_level", int'(fifo_level), 4);
    check("ovf_flag", int'(overflow), 1);
    seen_q.delete();
    byte_ready = 1'b1; idle(6); byte_ready = 1'b0;
    check("drain_count", seen_q.size(), 4);
    for (int i = 0; i < 4 && i < seen_q.size(); i++)
      check("drain_order", int'(seen_q[i]), i + 1);

    // Full FIFO, push coincides with pop
    restart();
    for (int i = 0; i < WARMUP; i++) feed(logic'($urandom_range(0, 1)));
    for (int v = 6; v <= 9; v++) feed_byte(8'(v));
    for (int i = 7; i >= 1; i--) feed(bit'(i == 3 || i == 1));
    byte_ready = 1'b1;
    feed(1'b0);
    byte_ready = 1'b0; bit_valid = 1'b0;
    check("pushpop_level", int'(fifo_level), 4);
    check("pushpop_no_ovf", int'(overflow), 0);
    check("pushpop_head", int'(byte_out), 8'h07);
    feed(1'b1); feed(1'b0); feed(1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Randomised run with biased segments to provoke trips
    bias = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 400 == 0) bias = int'($urandom_range(0, 3));
      enable     = ($urandom_range(0, 599) != 0);
      clear_fail = ($urandom_range(0, 99) == 0);
      byte_ready = ($urandom_range(0, 2) != 0);
      bit_valid  = ($urandom_range(0, 3) != 0);
      if (bias == 0) bit_in = ($urandom_range(0, 15) != 0);
      else           bit_in = logic'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    clear_fail = 1'b0; bit_valid = 1'b0; byte_ready = 1'b1;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ran_health_packer.md
Name: ran_health_packer

Overview:
- Downstream consumer of the post-processed random bit stream (XOR of the processed ring output and the 16-bit LFSR).
- Runs online health tests on every accepted bit: a repetition count test (RCT) and an adaptive proportion test (APT).
- Discards a warm-up interval, then packs bits MSB-first into bytes.
- Buffers bytes in a small FIFO with a valid/ready output handshake for an external reader.

Parameters:
- WARMUP_BITS, 64: accepted bits discarded after enable or clear before packing starts.
- RCT_CUTOFF, 32: run length of identical bits that declares RCT failure.
- APT_WINDOW, 512: APT window length in accepted bits.
- APT_CUTOFF, 410: count of reference-value bits in one window that declares APT failure.
- FIFO_DEPTH, 4: byte entries in the output FIFO; must be a power of 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- enable  in  1  run the block; low forces IDLE
- bit_in  in  1  random bit
- bit_valid  in  1  bit_in is accepted on a clk edge when high and state is not IDLE
- clear_fail  in  1  one-cycle pulse; leaves FAIL
- byte_out  out  8  FIFO head byte
- byte_valid  out  1  FIFO not empty
- byte_ready  in  1  reader pop; takes effect only when byte_valid is high
- fifo_level  out  clog2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  sticky; a packed byte was dropped because the FIFO was full
- health_fail  out  1  high while in FAIL
- fail_code  out  2  bit0 = RCT tripped, bit1 = APT tripped; sticky until cleared

Behaviour:
- Reset values (asynchronous, rst_n low):
  - state IDLE; all counters, pointers and the shift register 0.
  - byte_out 0, byte_valid 0, fifo_level 0, overflow 0, health_fail 0, fail_code 0.
- State machine: IDLE, WARMUP, RUN, FAIL.
  - IDLE -> WARMUP when enable is high.
  - Any state -> IDLE when enable is low. Entering IDLE clears the partial byte, bit counter, health counters and fail_code. FIFO contents are kept and remain drainable.
  - WARMUP -> RUN after WARMUP_BITS accepted bits.
  - WARMUP or RUN -> FAIL on any health trip.
  - FAIL -> WARMUP on clear_fail. This clears fail_code, the health counters and the partial byte.
- Health tests run on every accepted bit in WARMUP and RUN; they are frozen in IDLE and FAIL.
  - RCT: keep the last bit and a run counter. The counter is set to 1 when the bit differs from the last, otherwise incremented. The counter reaching RCT_CUTOFF trips RCT.
  - APT: the first bit of a window is the reference and the count starts at 1. Each later bit equal to the reference increments the count. The count reaching APT_CUTOFF trips APT. After APT_WINDOW bits a new window starts with the next bit.
  - A trip is registered on the clk edge that accepts the offending bit. health_fail and fail_code are high from the following cycle.
  - If both tests trip on the same bit, fail_code = 2'b11.
- FAIL entry:
  - Flushes the FIFO: level 0, byte_valid 0 the next cycle. Untested data is never delivered.
  - The partial byte is discarded.
  - Bits accepted in FAIL are ignored.
- Packing (RUN only):
  - Shift left, new bit into bit0, 3-bit counter.
  - On the 8th bit the byte is pushed to the FIFO on the same edge.
  - byte_valid rises the next cycle; latency from 8th-bit accept edge to byte_valid is 1 cycle.
  - The bit that trips a health test is never packed, and its byte is not pushed.
- FIFO:
  - Registered head, first-word fall-through.
  - Pop occurs when byte_valid and byte_ready are both high.
  - Push while full: allowed only if a pop occurs on the same edge (level unchanged). Otherwise the byte is dropped and overflow is set.
  - Push and pop on the same edge while not full: level unchanged.
  - Pop while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow is cleared only by reset or by entering IDLE.

Test Plan:
- Reset, enable=1, feed 64 warm-up bits then 8 bits 1,0,1,0,1,0,1,0 with byte_ready=1 -> no byte during warm-up; byte_valid high 1 cycle after the 8th bit; byte_out=8'hAA; fifo_level returns to 0 after the pop.
- After warm-up, feed 32 consecutive ones -> health_fail=1 and fail_code=2'b01 the cycle after the 32nd one; byte_valid=0; fifo_level=0; later bits produce no bytes.
- From the failed state, pulse clear_fail, then feed 64 + 16 alternating bits -> state passes through WARMUP; two bytes 8'hAA are delivered; fail_code=0.
- Repeat the pattern of 31 ones then 1 zero from the start of a window -> no RCT trip; APT trips at accepted bit 423 of the window; fail_code=2'b10.
- byte_ready=0, feed 5 full bytes (8'h01..8'h05) in RUN -> fifo_level=4; overflow=1 after the 5th byte; draining yields 8'h01..8'h04 in order.
- FIFO full, 6th byte completes on the same edge as a pop -> no drop; level stays 4. Then assert rst_n=0 mid-byte -> all outputs at reset values immediately.
